// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and opcode selection shared by the SPI flash sequencer
package spi_flash_pkg;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4
    } state_t;

    function automatic logic [7:0] opcode(input logic cmd);
        return cmd ? OP_READ : OP_RDID;
    endfunction
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: Mode-0 SCK half-period divider emitting rise/fall strobes on the clk edge where SCK changes
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    logic [7:0] cnt;
    logic       tick;

    assign tick = en && cnt == 8'(CLK_DIV - 1);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= 8'd0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: SPI Mode-0 flash read sequencer issuing RDID or READ and streaming received bytes
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_cmd,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    state_t      state;
    logic [30:0] sh;
    logic [10:0] bcnt;
    logic [10:0] last_bit;
    logic [7:0]  len;
    logic [6:0]  rx;
    logic [15:0] gcnt;
    logic        is_read;
    logic        fin;
    logic        active;
    logic        rise;
    logic        fall;
    logic [7:0]  op;

    assign active    = state == CMD || state == ADDR || state == DATA;
    assign req_ready = state == IDLE;
    assign busy      = active || done;
    assign last_bit  = {len - 8'd1, 3'b111};
    assign op        = opcode(req_cmd);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk  (clk),
        .rst  (rst),
        .en   (active),
        .sck  (spi_sck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= 31'd0;
            bcnt     <= 11'd0;
            len      <= 8'd0;
            rx       <= 7'd0;
            gcnt     <= 16'd0;
            is_read  <= 1'b0;
            fin      <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state    <= CMD;
                    sh       <= {op[6:0], req_addr};
                    spi_mosi <= op[7];
                    len      <= req_len;
                    is_read  <= req_cmd;
                    bcnt     <= 11'd0;
                    fin      <= 1'b0;
                    spi_cs_n <= 1'b0;
                end
                CMD, ADDR, DATA: begin
                    if (fall && fin) begin
                        state    <= GAP;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        gcnt     <= 16'd0;
                    end else if (fall) begin
                        sh       <= {sh[29:0], 1'b0};
                        spi_mosi <= state != DATA && sh[30];
                    end
                    if (rise) begin
                        bcnt <= bcnt + 11'd1;
                        if (state == CMD && bcnt == 11'd7) begin
                            state <= is_read ? ADDR : DATA;
                            bcnt  <= 11'd0;
                        end
                        if (state == ADDR && bcnt == 11'd23) begin
                            state <= DATA;
                            bcnt  <= 11'd0;
                        end
                        if (state == DATA) begin
                            rx <= {rx[5:0], spi_miso};
                            if (bcnt[2:0] == 3'd7) begin
                                rd_data  <= {rx, spi_miso};
                                rd_valid <= 1'b1;
                            end
                            if (bcnt == last_bit) fin <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 16'd1;
                    if (int'(gcnt) + 1 >= CS_GAP) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: directed bench with a Mode-0 flash model (memory[i]=i[7:0], ID EF 40 16)
module tb_spi_flash_seq;
    localparam int CS_GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv = 1'b0;
    logic        cmd = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [7:0]  len = 8'd0;
    logic        miso = 1'b0;
    logic        sel = 1'b0;

    logic       ready0, val0, done0, busy0, cs0, sck0, mosi0;
    logic       ready1, val1, done1, busy1, cs1, sck1, mosi1;
    logic [7:0] rd0, rd1;

    int n_chk = 0, n_fail = 0, ndone = 0, viol = 0, tot_rise = 0, rises = 0, cshi = 0;
    int hdr, d;
    logic [7:0]  b;
    logic [7:0]  opc = 8'd0;
    logic [23:0] adr = 24'd0;
    logic [7:0]  rxq[$];

    wire       m_cs    = sel ? cs1 : cs0;
    wire       m_sck   = sel ? sck1 : sck0;
    wire       m_mosi  = sel ? mosi1 : mosi0;
    wire       m_rv    = sel ? val1 : val0;
    wire [7:0] m_rd    = sel ? rd1 : rd0;
    wire       m_done  = sel ? done1 : done0;
    wire       m_busy  = sel ? busy1 : busy0;
    wire       m_ready = sel ? ready1 : ready0;

    always #5 clk = ~clk;

    spi_flash_seq #(.CLK_DIV(2), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(rv && !sel), .req_ready(ready0), .req_cmd(cmd),
        .req_addr(addr), .req_len(len), .rd_data(rd0), .rd_valid(val0), .done(done0),
        .busy(busy0), .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso)
    );

    spi_flash_seq #(.CLK_DIV(1), .CS_GAP(CS_GAP)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv && sel), .req_ready(ready1), .req_cmd(cmd),
        .req_addr(addr), .req_len(len), .rd_data(rd1), .rd_valid(val1), .done(done1),
        .busy(busy1), .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
    );

    function automatic logic [7:0] flash_byte(input logic [7:0] op, input logic [23:0] a, input int idx);
        logic [23:0] t;
        t = a + 24'(idx);
        if (op == 8'h9F) return (idx % 3 == 0) ? 8'hEF : (idx % 3 == 1) ? 8'h40 : 8'h16;
        return t[7:0];
    endfunction

    always @(negedge m_cs) begin
        rises = 0;
        opc = 8'd0;
        adr = 24'd0;
    end

    always @(posedge m_sck) if (!m_cs) begin
        rises++;
        tot_rise++;
        if (rises <= 8) opc = {opc[6:0], m_mosi};
        else if (opc == 8'h03 && rises <= 32) adr = {adr[22:0], m_mosi};
    end

    always @(negedge m_sck) if (!m_cs) begin
        hdr = (opc == 8'h03) ? 32 : 8;
        if (rises >= hdr) begin
            d = rises - hdr;
            b = flash_byte(opc, adr, d / 8);
            miso = b[7 - d % 8];
        end
    end

    always @(negedge clk) begin
        if (m_rv) rxq.push_back(m_rd);
        if (m_done) ndone++;
        if (m_busy && m_ready) viol++;
        cshi = m_cs ? cshi + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic c, input logic [23:0] a, input logic [7:0] l);
        int k;
        k = 0;
        while (!m_ready && k < 1000) begin
            tick;
            k++;
        end
        chk("ready_before_req", 32'(m_ready), 32'd1);
        cmd = c;
        addr = a;
        len = l;
        rv = 1'b1;
        @(posedge clk);
        #1;
        rv = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (ndone < n && k < 20000) begin
            tick;
            k++;
        end
        chk("done_count", 32'(ndone), 32'(n));
        tick;
    endtask

    initial begin
        int k;
        repeat (3) tick;
        chk("rst_cs_n", 32'(cs0), 32'd1);
        chk("rst_sck", 32'(sck0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_rd_data", 32'(rd0), 32'd0);
        chk("rst_rd_valid", 32'(val0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        tick;
        chk("rst_ready", 32'(ready0), 32'd1);

        rxq.delete();
        tot_rise = 0;
        start(1'b0, 24'hABCDEF, 8'd3);
        chk("rdid_busy", 32'(busy0), 32'd1);
        chk("rdid_cs_low", 32'(cs0), 32'd0);
        wait_done(1);
        chk("rdid_opcode", 32'(opc), 32'h9F);
        chk("rdid_rises", 32'(tot_rise), 32'd32);
        chk("rdid_count", 32'(rxq.size()), 32'd3);
        chk("rdid_b0", 32'(rxq[0]), 32'hEF);
        chk("rdid_b1", 32'(rxq[1]), 32'h40);
        chk("rdid_b2", 32'(rxq[2]), 32'h16);
        chk("rdid_cs_high", 32'(cs0), 32'd1);

        rxq.delete();
        tot_rise = 0;
        start(1'b1, 24'h000100, 8'd4);
        wait_done(2);
        chk("read_opcode", 32'(opc), 32'h03);
        chk("read_addr", 32'(adr), 32'h000100);
        chk("read_rises", 32'(tot_rise), 32'd64);
        chk("read_count", 32'(rxq.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("read_byte", 32'(rxq[i]), 32'(i));

        rxq.delete();
        start(1'b1, 24'h0012FE, 8'd4);
        wait_done(3);
        chk("wrap_addr", 32'(adr), 32'h0012FE);
        chk("wrap_count", 32'(rxq.size()), 32'd4);
        chk("wrap_b0", 32'(rxq[0]), 32'hFE);
        chk("wrap_b1", 32'(rxq[1]), 32'hFF);
        chk("wrap_b2", 32'(rxq[2]), 32'h00);
        chk("wrap_b3", 32'(rxq[3]), 32'h01);

        rxq.delete();
        viol = 0;
        k = 0;
        while (!m_ready && k < 1000) begin
            tick;
            k++;
        end
        cmd = 1'b0;
        len = 8'd1;
        rv = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy", 32'(busy0), 32'd1);
        chk("b2b_not_ready", 32'(ready0), 32'd0);
        k = 0;
        while (!m_ready && k < 2000) begin
            tick;
            k++;
        end
        chk("b2b_first_done", 32'(ndone), 32'd4);
        chk("b2b_cs_gap", 32'(cshi >= CS_GAP), 32'd1);
        @(posedge clk);
        #1;
        rv = 1'b0;
        chk("b2b_second_busy", 32'(busy0), 32'd1);
        wait_done(5);
        chk("b2b_ready_vs_busy", 32'(viol), 32'd0);
        chk("b2b_count", 32'(rxq.size()), 32'd2);
        chk("b2b_b0", 32'(rxq[0]), 32'hEF);
        chk("b2b_b1", 32'(rxq[1]), 32'hEF);

        rxq.delete();
        tot_rise = 0;
        start(1'b1, 24'h000200, 8'd4);
        k = 0;
        while (tot_rise < 17 && k < 1000) begin
            tick;
            k++;
        end
        chk("abort_in_addr", 32'(tot_rise), 32'd17);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs0), 32'd1);
        chk("abort_sck", 32'(sck0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        repeat (2) tick;
        rst = 1'b0;
        repeat (40) tick;
        chk("abort_no_done", 32'(ndone), 32'd5);
        chk("abort_no_data", 32'(rxq.size()), 32'd0);
        start(1'b0, 24'h000000, 8'd3);
        wait_done(6);
        chk("post_abort_count", 32'(rxq.size()), 32'd3);
        chk("post_abort_b0", 32'(rxq[0]), 32'hEF);
        chk("post_abort_b1", 32'(rxq[1]), 32'h40);
        chk("post_abort_b2", 32'(rxq[2]), 32'h16);

        repeat (10) tick;
        sel = 1'b1;
        rxq.delete();
        tot_rise = 0;
        start(1'b1, 24'h0000F0, 8'd0);
        wait_done(7);
        chk("len0_rises", 32'(tot_rise), 32'd2080);
        chk("len0_count", 32'(rxq.size()), 32'd256);
        for (int i = 0; i < 256; i++) chk("len0_byte", 32'(rxq[i]), 32'((8'hF0 + i) % 256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_flash_seq.md
SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set clk cycles per SCK half-period (legal 1..255).
REQ-002 Parameter CS_GAP, default 4, SHALL set the minimum clk cycles spi_cs_n stays high between transactions.
REQ-003 clk  input  1  single clock; all state SHALL be sampled on its rising edge.
REQ-004 rst  input  1  reset SHALL be asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  high only in IDLE with the CS gap elapsed.
REQ-007 req_cmd  input  1  0 = RDID (0x9F), 1 = READ (0x03).
REQ-008 req_addr  input  24  READ byte address; ignored for RDID.
REQ-009 req_len  input  8  bytes to read, 1..255; 0 SHALL mean 256.
REQ-010 rd_data  output  8  received byte, MSB first on the wire.
REQ-011 rd_valid  output  1  one-cycle strobe per byte, no backpressure.
REQ-012 done  output  1  one-cycle strobe at transaction end.
REQ-013 busy  output  1  high from accept until done inclusive.
REQ-014 spi_cs_n  output  1  flash chip select, active low.
REQ-015 spi_sck  output  1  SPI clock, Mode 0, idle low.
REQ-016 spi_mosi  output  1  master data out.
REQ-017 spi_miso  input  1  flash data in.

Function
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, DATA and GAP.
REQ-019 A request SHALL be accepted on the cycle req_valid && req_ready; command, address and length SHALL be latched then.
REQ-020 On the cycle after accept: spi_cs_n=0, spi_sck=0, spi_mosi=opcode[7], state CMD.
REQ-021 spi_sck SHALL toggle every CLK_DIV clk cycles while in CMD, ADDR or DATA; the first rising edge SHALL come CLK_DIV cycles after spi_cs_n falls.
REQ-022 spi_mosi SHALL change only on the clk where spi_sck falls, or at CS assertion for bit 0, and SHALL be stable across each rising edge.
REQ-023 CMD SHALL shift out 8 opcode bits MSB first; after the 8th rising edge go to ADDR for READ or DATA for RDID.
REQ-024 ADDR SHALL shift out 24 bits MSB first; after the 24th rising edge go to DATA.
REQ-025 spi_mosi SHALL be 0 during DATA.
REQ-026 DATA SHALL sample spi_miso on the clk where spi_sck rises, shifting MSB first.
REQ-027 After each 8th data bit, rd_data SHALL update and rd_valid SHALL pulse on the next clk.
REQ-028 DATA SHALL end after len*8 rising edges.
REQ-029 After the last data rising edge, spi_sck SHALL return low after CLK_DIV cycles; spi_cs_n SHALL then go high and done SHALL pulse in that same cycle.
REQ-030 GAP SHALL hold spi_cs_n=1 and spi_sck=0 for CS_GAP cycles, then go to IDLE.
REQ-031 Total SCK rising edges per transaction SHALL be 8 + (READ ? 24 : 0) + 8*len.
REQ-032 While busy, req_valid SHALL be ignored and req_ready SHALL be 0.
REQ-033 The 24-bit address SHALL be sent unmodified; address wrap belongs to the flash, not this block.

Reset
REQ-034 On rst, state SHALL be IDLE and outputs SHALL be: spi_cs_n=1, spi_sck=0, spi_mosi=0, rd_data=0, rd_valid=0, done=0, busy=0.
REQ-035 On rst, req_ready SHALL be 1 after release.
REQ-036 rst mid-transaction SHALL abort immediately: no done, no further rd_valid; the next transaction SHALL start cleanly.

Structure
REQ-037 Package spi_flash_pkg SHALL hold the opcode constants (OP_RDID=8'h9F, OP_READ=8'h03) and the state enum.
REQ-038 Sub-module spi_sck_gen SHALL hold the half-period counter and emit rise/fall strobes to the FSM.

Verification (bench uses the Mode-0 flash model, memory[i]=i[7:0], ID EF 40 16)
REQ-039 RDID, len=3 -> rd_data EF, 40, 16; done once; 32 SCK rising edges.
REQ-040 READ addr=0x000100, len=4 -> rd_data 00, 01, 02, 03; 64 SCK rising edges.
REQ-041 READ addr=0x0012FE, len=4 -> FE, FF, 00, 01 (byte-wrap of data pattern).
REQ-042 Two back-to-back requests with req_valid held high -> second accept only after spi_cs_n has been high ≥CS_GAP cycles; req_ready=0 throughout the first.
REQ-043 rst asserted during ADDR of a READ -> spi_cs_n=1 and spi_sck=0 asynchronously; no done; a following RDID returns EF 40 16.
REQ-044 READ with len=0, CLK_DIV=1 -> 256 rd_valid pulses, bytes addr[7:0] upward, wrapping at FF.
